ahb_slave_if_param: RTL and testbench

//  Parametrised AHB-side front end of the AHB2APB bridge; sits between the AHB master and the bridge APB FSM.

---
 rtl/ahb_apb_pkg.sv | 24 ++
 rtl/ahb_addr_decoder.sv | 44 ++++
 rtl/ahb_slave_if_param.sv | 150 +++++++++++++++
 tb/tb_ahb_slave_if_param.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge definitions: transfer type and response encodings,
// the error-response state type and a small transfer-qualification helper.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ERR1 = 2'd1,
    ERR_ERR2 = 2'd2
  } err_state_e;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational decode of an AHB address into NUM_SLV equal, contiguous APB
// regions starting at BASE_ADDR; produces a range flag and a one-hot select.
module ahb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic [ADDR_W-1:0]  haddr,
  output logic               in_range,
  output logic [NUM_SLV-1:0] temp_sel
);

  // Extra headroom bits so the region limit itself cannot wrap.
  localparam int               EXT_W = ADDR_W + 4;
  localparam logic [EXT_W-1:0] LIMIT = EXT_W'(BASE_ADDR) + EXT_W'(NUM_SLV) * EXT_W'(SLV_SIZE);
  localparam int               SHIFT = $clog2(SLV_SIZE);

  if (NUM_SLV < 1 || NUM_SLV > 8) begin : g_bad_num_slv
    $error("ahb_addr_decoder: NUM_SLV must be in 1..8");
  end
  if ((SLV_SIZE == '0) || ((SLV_SIZE & (SLV_SIZE - 1'b1)) != '0)) begin : g_bad_size
    $error("ahb_addr_decoder: SLV_SIZE must be a power of two");
  end
  if (LIMIT > (EXT_W'(1) << ADDR_W)) begin : g_overflow
    $error("ahb_addr_decoder: BASE_ADDR + NUM_SLV*SLV_SIZE overflows ADDR_W");
  end

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] slot;

  always_comb begin
    offset   = haddr - BASE_ADDR;
    slot     = offset >> SHIFT;
    in_range = (EXT_W'(haddr) >= EXT_W'(BASE_ADDR)) && (EXT_W'(haddr) < LIMIT);
    temp_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (in_range && (slot == ADDR_W'(i))) temp_sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB-side front end of the AHB2APB bridge: decode, transfer qualification,
// address/control pipeline, data-phase write capture and HREADYOUT/HRESP.
// Define AHB_SLV_ERR_RESP_EN to answer unmapped transfers with a two-cycle ERROR.
module ahb_slave_if_param
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_SLV    = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE   = 32'h0400_0000,
  parameter int                PIPE_DEPTH = 2
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         hready_in,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [DATA_W-1:0]            hwdata,
  input  logic [DATA_W-1:0]            pr_data,
  input  logic                         apb_ready,
  output logic                         valid,
  output logic [NUM_SLV-1:0]           temp_sel,
  output logic [PIPE_DEPTH*ADDR_W-1:0] haddr_q,
  output logic [PIPE_DEPTH-1:0]        hwrite_q,
  output logic [NUM_SLV-1:0]           sel_q,
  output logic [DATA_W-1:0]            hwdata_q,
  output logic                         hready_out,
  output logic [1:0]                   hresp,
  output logic [DATA_W-1:0]            hr_data
);

  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("ahb_slave_if_param: PIPE_DEPTH must be at least 1");
  end

  logic in_range;
  logic active;
  logic err_hit;

  ahb_addr_decoder #(
    .ADDR_W    (ADDR_W),
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SIZE  (SLV_SIZE)
  ) u_addr_decoder (
    .haddr    (haddr),
    .in_range (in_range),
    .temp_sel (temp_sel)
  );

  assign active  = hready_in && htrans_active(htrans);
  assign valid   = active && in_range;
  assign hr_data = pr_data;

`ifdef AHB_SLV_ERR_RESP_EN
  assign err_hit = active && !in_range;
`else
  assign err_hit = 1'b0;
`endif

  // Address/control pipeline and data-phase capture; everything freezes while hready_in is low.
  logic [ADDR_W-1:0]     addr_pipe_q [PIPE_DEPTH];
  logic [ADDR_W-1:0]     addr_pipe_d [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] hwrite_d;
  logic [NUM_SLV-1:0]    sel_d;
  logic [DATA_W-1:0]     hwdata_d;
  logic                  wr_pend_q;
  logic                  wr_pend_d;

  always_comb begin
    addr_pipe_d = addr_pipe_q;
    hwrite_d    = hwrite_q;
    sel_d       = sel_q;
    hwdata_d    = hwdata_q;
    wr_pend_d   = wr_pend_q;
    if (hready_in) begin
      addr_pipe_d[0] = haddr;
      hwrite_d[0]    = hwrite;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        addr_pipe_d[k] = addr_pipe_q[k-1];
        hwrite_d[k]    = hwrite_q[k-1];
      end
      sel_d     = valid ? temp_sel : '0;
      wr_pend_d = valid && hwrite;
      if (wr_pend_q) hwdata_d = hwdata;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int k = 0; k < PIPE_DEPTH; k++) addr_pipe_q[k] <= '0;
      hwrite_q  <= '0;
      sel_q     <= '0;
      hwdata_q  <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      addr_pipe_q <= addr_pipe_d;
      hwrite_q    <= hwrite_d;
      sel_q       <= sel_d;
      hwdata_q    <= hwdata_d;
      wr_pend_q   <= wr_pend_d;
    end
  end

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_addr_flat
    assign haddr_q[g*ADDR_W +: ADDR_W] = addr_pipe_q[g];
  end

  // Response FSM; an unmapped transfer wins over APB back-pressure.
  err_state_e state_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ERR_IDLE;
      hready_out <= 1'b1;
      hresp      <= HRESP_OKAY;
    end else begin
      case (state_q)
        ERR_IDLE: begin
          if (err_hit) begin
            state_q    <= ERR_ERR1;
            hready_out <= 1'b0;
            hresp      <= HRESP_ERROR;
          end else begin
            hready_out <= apb_ready;
            hresp      <= HRESP_OKAY;
          end
        end
        ERR_ERR1: begin
          state_q    <= ERR_ERR2;
          hready_out <= 1'b1;
          hresp      <= HRESP_ERROR;
        end
        ERR_ERR2: begin
          state_q    <= ERR_IDLE;
          hready_out <= apb_ready;
          hresp      <= HRESP_OKAY;
        end
        default: begin
          state_q    <= ERR_IDLE;
          hready_out <= 1'b1;
          hresp      <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Directed bench for ahb_slave_if_param: default 3-slave instance plus an
// 8-slave, 4 KiB-region instance for the decode boundary.
module tb_ahb_slave_if_param;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hready_in;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] haddr8;
  logic [31:0] hwdata;
  logic [31:0] pr_data;
  logic        apb_ready;

  logic        valid;
  logic [2:0]  temp_sel;
  logic [63:0] haddr_q;
  logic [1:0]  hwrite_q;
  logic [2:0]  sel_q;
  logic [31:0] hwdata_q;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hr_data;

  logic        valid8;
  logic [7:0]  temp_sel8;
  logic [63:0] haddr_q8;
  logic [1:0]  hwrite_q8;
  logic [7:0]  sel_q8;
  logic [31:0] hwdata_q8;
  logic        hready_out8;
  logic [1:0]  hresp8;
  logic [31:0] hr_data8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 hclk = ~hclk;

  ahb_slave_if_param u_dut (
    .hclk(hclk), .hresetn(hresetn), .hready_in(hready_in), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .pr_data(pr_data),
    .apb_ready(apb_ready), .valid(valid), .temp_sel(temp_sel), .haddr_q(haddr_q),
    .hwrite_q(hwrite_q), .sel_q(sel_q), .hwdata_q(hwdata_q), .hready_out(hready_out),
    .hresp(hresp), .hr_data(hr_data)
  );

  ahb_slave_if_param #(.NUM_SLV(8), .SLV_SIZE(32'h0000_1000)) u_dut8 (
    .hclk(hclk), .hresetn(hresetn), .hready_in(hready_in), .htrans(htrans),
    .hwrite(hwrite), .haddr(haddr8), .hwdata(hwdata), .pr_data(pr_data),
    .apb_ready(apb_ready), .valid(valid8), .temp_sel(temp_sel8), .haddr_q(haddr_q8),
    .hwrite_q(hwrite_q8), .sel_q(sel_q8), .hwdata_q(hwdata_q8), .hready_out(hready_out8),
    .hresp(hresp8), .hr_data(hr_data8)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; hready_in = 1'b1; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; haddr8 = '0; hwdata = '0; pr_data = '0; apb_ready = 1'b0;
    tick(); tick();
    n_total++; if (hready_out !== 1'b1) $display("FAIL rst_hready_out got=%b exp=1", hready_out); else n_pass++;
    n_total++; if (hresp !== 2'b00) $display("FAIL rst_hresp got=%b exp=00", hresp); else n_pass++;
    n_total++; if (haddr_q !== 64'h0) $display("FAIL rst_haddr_q got=%h exp=0", haddr_q); else n_pass++;
    n_total++; if (sel_q !== 3'b000 || hwrite_q !== 2'b00) $display("FAIL rst_sel_hwrite got=%b/%b exp=000/00", sel_q, hwrite_q); else n_pass++;
    n_total++; if (hwdata_q !== 32'h0) $display("FAIL rst_hwdata_q got=%h exp=0", hwdata_q); else n_pass++;
    apb_ready = 1'b1;
    #2 hresetn = 1'b1;
    tick();
    n_total++; if (hready_out !== 1'b1) $display("FAIL rst_release_hready got=%b exp=1", hready_out); else n_pass++;
  endtask

  task automatic test_write();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8400_0010;
    #1;
    n_total++; if (valid !== 1'b1) $display("FAIL wr_valid got=%b exp=1", valid); else n_pass++;
    n_total++; if (temp_sel !== 3'b010) $display("FAIL wr_temp_sel got=%b exp=010", temp_sel); else n_pass++;
    tick();
    n_total++; if (sel_q !== 3'b010) $display("FAIL wr_sel_q got=%b exp=010", sel_q); else n_pass++;
    n_total++; if (haddr_q[31:0] !== 32'h8400_0010) $display("FAIL wr_stage0 got=%h exp=84000010", haddr_q[31:0]); else n_pass++;
    n_total++; if (hwrite_q[0] !== 1'b1) $display("FAIL wr_hwrite_q0 got=%b exp=1", hwrite_q[0]); else n_pass++;
    htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'hA5A5_A5A5; pr_data = 32'h1234_5678;
    tick();
    n_total++; if (hwdata_q !== 32'hA5A5_A5A5) $display("FAIL wr_hwdata_q got=%h exp=a5a5a5a5", hwdata_q); else n_pass++;
    n_total++; if (haddr_q[63:32] !== 32'h8400_0010) $display("FAIL wr_stage1 got=%h exp=84000010", haddr_q[63:32]); else n_pass++;
    n_total++; if (hwrite_q !== 2'b10) $display("FAIL wr_hwrite_q got=%b exp=10", hwrite_q); else n_pass++;
    n_total++; if (sel_q !== 3'b000) $display("FAIL wr_sel_clear got=%b exp=000", sel_q); else n_pass++;
    n_total++; if (hr_data !== 32'h1234_5678) $display("FAIL hr_data got=%h exp=12345678", hr_data); else n_pass++;
  endtask

  task automatic test_busy_idle();
    htrans = 2'b10; haddr = 32'h8000_0000;
    tick();
    n_total++; if (sel_q !== 3'b001) $display("FAIL bi_sel_nonseq got=%b exp=001", sel_q); else n_pass++;
    htrans = 2'b01;
    #1;
    n_total++; if (valid !== 1'b0) $display("FAIL bi_busy_valid got=%b exp=0", valid); else n_pass++;
    tick();
    n_total++; if (sel_q !== 3'b000) $display("FAIL bi_busy_sel got=%b exp=000", sel_q); else n_pass++;
    htrans = 2'b10;
    tick();
    htrans = 2'b00;
    #1;
    n_total++; if (valid !== 1'b0) $display("FAIL bi_idle_valid got=%b exp=0", valid); else n_pass++;
    tick();
    n_total++; if (sel_q !== 3'b000) $display("FAIL bi_idle_sel got=%b exp=000", sel_q); else n_pass++;
  endtask

  task automatic test_wait_states();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8800_0000;
    tick();
    htrans = 2'b11; haddr = 32'h8800_0004; hwdata = 32'h1111_2222;
    tick();
    hready_in = 1'b0; haddr = 32'h8800_0008; hwdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (valid !== 1'b0) $display("FAIL ws_valid_low got=%b exp=0", valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (haddr_q !== {32'h8800_0000, 32'h8800_0004} || sel_q !== 3'b100 || hwdata_q !== 32'h1111_2222)
        $display("FAIL ws_hold%0d got=%h/%b/%h exp=8800000088000004/100/11112222", i, haddr_q, sel_q, hwdata_q);
      else n_pass++;
    end
    hready_in = 1'b1; hwdata = 32'h3333_4444;
    tick();
    n_total++;
    if (haddr_q !== {32'h8800_0004, 32'h8800_0008} || hwdata_q !== 32'h3333_4444 || sel_q !== 3'b100)
      $display("FAIL ws_resume got=%h/%h/%b exp=8800000488000008/33334444/100", haddr_q, hwdata_q, sel_q);
    else n_pass++;
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h7777_8888;
    tick();
    n_total++; if (hwdata_q !== 32'h7777_8888) $display("FAIL ws_last_data got=%h exp=77778888", hwdata_q); else n_pass++;
  endtask

  task automatic test_unmapped();
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h9000_0000;
    #1;
    n_total++; if (valid !== 1'b0 || temp_sel !== 3'b000) $display("FAIL um_decode got=%b/%b exp=0/000", valid, temp_sel); else n_pass++;
    tick();
    htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0;
`ifdef AHB_SLV_ERR_RESP_EN
    n_total++; if (hready_out !== 1'b0 || hresp !== 2'b01) $display("FAIL um_err1 got=%b/%b exp=0/01", hready_out, hresp); else n_pass++;
    hready_in = 1'b0;
    tick();
    n_total++; if (hready_out !== 1'b1 || hresp !== 2'b01) $display("FAIL um_err2 got=%b/%b exp=1/01", hready_out, hresp); else n_pass++;
    hready_in = 1'b1;
    tick();
    n_total++; if (hready_out !== 1'b1 || hresp !== 2'b00) $display("FAIL um_okay got=%b/%b exp=1/00", hready_out, hresp); else n_pass++;
`else
    n_total++; if (hready_out !== 1'b1 || hresp !== 2'b00) $display("FAIL um_nostall got=%b/%b exp=1/00", hready_out, hresp); else n_pass++;
`endif
    n_total++; if (sel_q !== 3'b000) $display("FAIL um_sel_q got=%b exp=000", sel_q); else n_pass++;
  endtask

  task automatic test_map8();
    htrans = 2'b10; haddr = 32'h8000_0000; haddr8 = 32'h8000_7FFC;
    #1;
    n_total++; if (temp_sel8 !== 8'b1000_0000 || valid8 !== 1'b1) $display("FAIL m8_top got=%b/%b exp=10000000/1", temp_sel8, valid8); else n_pass++;
    haddr8 = 32'h8000_8000;
    #1;
    n_total++; if (temp_sel8 !== 8'h00 || valid8 !== 1'b0) $display("FAIL m8_limit got=%b/%b exp=00000000/0", temp_sel8, valid8); else n_pass++;
    haddr8 = 32'h8000_0FFF;
    #1;
    n_total++; if (temp_sel8 !== 8'b0000_0001) $display("FAIL m8_slot0 got=%b exp=00000001", temp_sel8); else n_pass++;
    n_total++; if (hr_data8 !== 32'h1234_5678) $display("FAIL m8_hr_data got=%h exp=12345678", hr_data8); else n_pass++;
    htrans = 2'b00; haddr = 32'h0; haddr8 = 32'h0;
    #1;
  endtask

  task automatic test_ready_and_reset();
    apb_ready = 1'b0;
    tick();
    n_total++; if (hready_out !== 1'b0) $display("FAIL rr_backpressure got=%b exp=0", hready_out); else n_pass++;
    apb_ready = 1'b1;
    tick();
    n_total++; if (hready_out !== 1'b1) $display("FAIL rr_ready got=%b exp=1", hready_out); else n_pass++;
    htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0100;
    tick();
    hwrite = 1'b0; haddr = 32'h9000_0000; hwdata = 32'h5555_6666;
    tick();
    n_total++; if (hwdata_q !== 32'h5555_6666) $display("FAIL rr_pre_data got=%h exp=55556666", hwdata_q); else n_pass++;
`ifdef AHB_SLV_ERR_RESP_EN
    n_total++; if (hresp !== 2'b01) $display("FAIL rr_in_err1 got=%b exp=01", hresp); else n_pass++;
`endif
    hresetn = 1'b0;
    #1;
    n_total++; if (hresp !== 2'b00 || hready_out !== 1'b1) $display("FAIL rr_async_resp got=%b/%b exp=00/1", hresp, hready_out); else n_pass++;
    n_total++;
    if (haddr_q !== 64'h0 || hwrite_q !== 2'b00 || sel_q !== 3'b000 || hwdata_q !== 32'h0)
      $display("FAIL rr_async_regs got=%h/%b/%b/%h exp=0/00/000/0", haddr_q, hwrite_q, sel_q, hwdata_q);
    else n_pass++;
    htrans = 2'b00; haddr = 32'h0;
    #2 hresetn = 1'b1;
    tick(); tick();
    n_total++; if (hready_out !== 1'b1 || hresp !== 2'b00) $display("FAIL rr_after got=%b/%b exp=1/00", hready_out, hresp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_busy_idle();
    test_wait_states();
    test_unmapped();
    test_map8();
    test_ready_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
